// File: rtl/hpdcache_sram_wbe_coalesce_1rw.sv
// Write-coalescing request stage in front of a 1RW byte-enable SRAM macro.
// A single-entry buffer absorbs partial writes, merges same-row writes,
// forwards its bytes into read data, and drains to the SRAM on an address
// change, an idle timeout or a flush request.
module hpdcache_sram_wbe_coalesce_1rw #(
    parameter int ADDR_SIZE     = 6,
    parameter int DATA_SIZE     = 64,
    parameter int NDATA         = 1,
    parameter int DRAIN_TIMEOUT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_we_i,
    input  logic [ADDR_SIZE-1:0]           req_addr_i,
    input  logic [NDATA*DATA_SIZE-1:0]     req_wdata_i,
    input  logic [NDATA*DATA_SIZE/8-1:0]   req_be_i,

    output logic                           rsp_valid_o,
    output logic [NDATA*DATA_SIZE-1:0]     rsp_rdata_o,

    input  logic                           flush_i,
    output logic                           flush_done_o,

    output logic                           sram_cs_o,
    output logic                           sram_we_o,
    output logic [ADDR_SIZE-1:0]           sram_addr_o,
    output logic [NDATA*DATA_SIZE-1:0]     sram_wdata_o,
    output logic [NDATA*DATA_SIZE/8-1:0]   sram_wbe_o,
    input  logic [NDATA*DATA_SIZE-1:0]     sram_rdata_i
);

    localparam int WIDTH  = NDATA * DATA_SIZE;
    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q;
    logic                   flush_pend_q;
    logic                   flush_done_q;

    logic                   wbuf_valid_q, wbuf_valid_d;
    logic [ADDR_SIZE-1:0]   wbuf_addr_q,  wbuf_addr_d;
    logic [WIDTH-1:0]       wbuf_data_q,  wbuf_data_d;
    logic [NBYTES-1:0]      wbuf_be_q,    wbuf_be_d;

    logic [CNT_W-1:0]       idle_cnt_q,   idle_cnt_d;

    logic                   rsp_valid_q;
    logic [WIDTH-1:0]       fwd_data_q;
    logic [NBYTES-1:0]      fwd_be_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                   req_acc;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   addr_hit;
    logic                   miss_drain;
    logic                   flush_drain;
    logic                   timeout_drain;
    logic                   drain;
    logic [WIDTH-1:0]       merge_data;

    // Requests are only taken in RUN and never while reset is asserted.
    assign req_ready_o = rst_n & (state_q == ST_RUN);
    assign req_acc     = req_valid_i & req_ready_o;

    // A write with no byte enabled carries nothing; treating it as a no-op
    // keeps the entry from ever holding an all-zero byte mask.
    assign wr_acc      = req_acc & req_we_i & (|req_be_i);
    assign rd_acc      = req_acc & ~req_we_i;
    assign addr_hit    = wbuf_valid_q & (req_addr_i == wbuf_addr_q);

    // Drain sources. They are mutually exclusive with a read: a miss drain
    // needs an accepted write, a timeout drain needs an idle cycle, and a
    // flush drain happens while requests are blocked.
    assign miss_drain  = wr_acc & wbuf_valid_q & ~addr_hit;
    assign flush_drain = flush_pend_q & wbuf_valid_q;
    assign drain       = rst_n & (miss_drain | flush_drain | timeout_drain);

    // Byte-wise merge of an incoming write over the buffered word, and of
    // forwarded bytes over SRAM read data.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign merge_data[gi*8 +: 8]  = req_be_i[gi] ? req_wdata_i[gi*8 +: 8]
                                                         : wbuf_data_q[gi*8 +: 8];
            assign rsp_rdata_o[gi*8 +: 8] = fwd_be_q[gi] ? fwd_data_q[gi*8 +: 8]
                                                         : sram_rdata_i[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------
    generate
        if (DRAIN_TIMEOUT > 0) begin : g_timeout
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

            // The idle cycle that brings the count to DRAIN_TIMEOUT drains.
            assign timeout_drain = ~req_acc & wbuf_valid_q & (idle_cnt_q >= CNT_LAST);

            // Count consecutive idle cycles, saturating; restart on activity
            // or on a timeout drain.
            always_comb begin
                idle_cnt_d = idle_cnt_q;
                if (req_acc || timeout_drain) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q < CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign timeout_drain = 1'b0;

            // Auto-drain disabled: the counter stays parked at zero.
            always_comb begin
                idle_cnt_d = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write buffer next state
    // ------------------------------------------------------------------
    // Drain empties the entry first; an accepted write then merges (hit) or
    // reloads it (empty or miss) in the same cycle.
    always_comb begin
        wbuf_valid_d = wbuf_valid_q;
        wbuf_addr_d  = wbuf_addr_q;
        wbuf_data_d  = wbuf_data_q;
        wbuf_be_d    = wbuf_be_q;

        if (drain) begin
            wbuf_valid_d = 1'b0;
            wbuf_be_d    = '0;
        end

        if (wr_acc) begin
            if (addr_hit) begin
                wbuf_data_d = merge_data;
                wbuf_be_d   = wbuf_be_q | req_be_i;
            end else begin
                wbuf_valid_d = 1'b1;
                wbuf_addr_d  = req_addr_i;
                wbuf_data_d  = req_wdata_i;
                wbuf_be_d    = req_be_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM port
    // ------------------------------------------------------------------
    // One access per cycle: either a drain write of the buffered entry or
    // the read of an accepted read request.
    always_comb begin
        sram_cs_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = wbuf_data_q;
        sram_wbe_o   = wbuf_be_q;
        if (drain) begin
            sram_cs_o   = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = wbuf_addr_q;
        end else if (rst_n && rd_acc) begin
            sram_cs_o   = 1'b1;
            sram_addr_o = req_addr_i;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // Control state of the buffer, idle counter and read response; a
    // buffered write is intentionally lost on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbuf_valid_q <= 1'b0;
            wbuf_be_q    <= '0;
            idle_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            fwd_be_q     <= '0;
        end else begin
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_be_q    <= wbuf_be_d;
            idle_cnt_q   <= idle_cnt_d;
            rsp_valid_q  <= rd_acc;
            if (rd_acc) begin
                fwd_be_q <= addr_hit ? wbuf_be_q : '0;
            end
        end
    end

    // Payload registers need no reset: they are qualified by valid/be.
    always_ff @(posedge clk) begin
        wbuf_addr_q <= wbuf_addr_d;
        wbuf_data_q <= wbuf_data_d;
        if (rd_acc) begin
            fwd_data_q <= wbuf_data_q;
        end
    end

    // RUN/FLUSH sequencer; flush_done is registered so it is high exactly
    // during the single FLUSH cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush_i) begin
                        state_q      <= ST_FLUSH;
                        flush_pend_q <= 1'b1;
                        flush_done_q <= 1'b1;
                    end else begin
                        flush_done_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_q      <= ST_RUN;
                    flush_pend_q <= 1'b0;
                    flush_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_RUN;
                    flush_pend_q <= 1'b0;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_hpdcache_sram_wbe_coalesce_1rw.sv
// Scoreboard bench for the SRAM write-coalescing stage: directed stimulus
// pushes expected SRAM writes and read responses into queues; monitors pop
// and compare whenever the DUT presents them.
module tb_hpdcache_sram_wbe_coalesce_1rw;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [5:0]  req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_be_i;
    logic        rsp_valid_o;
    logic [63:0] rsp_rdata_o;
    logic        flush_i;
    logic        flush_done_o;
    logic        sram_cs_o;
    logic        sram_we_o;
    logic [5:0]  sram_addr_o;
    logic [63:0] sram_wdata_o;
    logic [7:0]  sram_wbe_o;
    logic [63:0] sram_rdata_i;

    typedef struct packed {
        logic [5:0]  a;
        logic [7:0]  be;
        logic [63:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [63:0] rd_q[$];
    wr_t         mon_w;
    logic [63:0] mon_r;

    int total = 0;
    int bad   = 0;

    hpdcache_sram_wbe_coalesce_1rw #(
        .ADDR_SIZE     (6),
        .DATA_SIZE     (64),
        .NDATA         (1),
        .DRAIN_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_be_i     (req_be_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .sram_cs_o    (sram_cs_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_wbe_o   (sram_wbe_o),
        .sram_rdata_i (sram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: row a initialises to {a+0x10, C0..C5, 0x55}.
    logic [63:0] mem [64];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 64; a++) begin
                mem[a] <= {8'(a) + 8'h10, 48'hC0C1C2C3C4C5, 8'h55};
            end
            mem_init <= 1'b1;
        end else if (sram_cs_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 8; b++) begin
                    if (sram_wbe_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
                end
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    function automatic logic [63:0] bmask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: SRAM writes and read responses against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sram_cs_o === 1'b1 && sram_we_o === 1'b1) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sram_write actual addr=%0d wbe=%h required no write",
                         sram_addr_o, sram_wbe_o);
            end else begin
                mon_w = wr_q.pop_front();
                $display("txn sram_wr addr=%0d wbe=%h data=%h", sram_addr_o, sram_wbe_o, sram_wdata_o);
                chk("wr_addr", 64'(sram_addr_o), 64'(mon_w.a));
                chk("wr_wbe", 64'(sram_wbe_o), 64'(mon_w.be));
                chk("wr_data", sram_wdata_o & bmask(mon_w.be), mon_w.d & bmask(mon_w.be));
            end
        end
        if (rsp_valid_o === 1'b1) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual=%h required no response", rsp_rdata_o);
            end else begin
                mon_r = rd_q.pop_front();
                $display("txn rsp data=%h", rsp_rdata_o);
                chk("rsp_data", rsp_rdata_o, mon_r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = a;
        req_wdata_i = d;
        req_be_i    = be;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [63:0] exp);
        rd_q.push_back(exp);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = a;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [7:0] be, input logic [63:0] d);
        wr_t w;
        w.a  = a;
        w.be = be;
        w.d  = d;
        wr_q.push_back(w);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        flush_i     = 1'b0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_cs", 64'(sram_cs_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_flush_done", 64'(flush_done_o), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("run_ready", 64'(req_ready_o), 64'd1);
        tick();

        // 1: reset discards a buffered write
        wr(6'd3, 64'h00000000AABBCCDD, 8'h0F);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(req_ready_o), 64'd0);
        tick();
        rst_n = 1'b1;
        idle(6);
        rd(6'd3, 64'h13C0C1C2C3C4C555);
        idle(2);

        // 2: merge two writes to a=5, drained by the miss to a=9
        push_wr(6'd5, 8'hFF, 64'h2222222211111111);
        wr(6'd5, 64'h1111111111111111, 8'h0F);
        wr(6'd5, 64'h2222222222222222, 8'hF0);
        push_wr(6'd9, 8'hFF, 64'h9999999999999999);
        wr(6'd9, 64'h9999999999999999, 8'hFF);
        idle(5);
        rd(6'd5, 64'h2222222211111111);
        rd(6'd9, 64'h9999999999999999);
        idle(2);

        // 3: forward buffered byte; 4: read snapshot ignores later merge
        wr(6'd2, 64'h00000000000000AA, 8'h01);
        rd(6'd2, 64'h12C0C1C2C3C4C5AA);
        rd(6'd2, 64'h12C0C1C2C3C4C5AA);
        push_wr(6'd2, 8'h03, 64'h000000000000BBAA);
        wr(6'd2, 64'h000000000000BB00, 8'h02);
        idle(5);

        // 5: idle timeout drains on the 4th idle cycle
        push_wr(6'd7, 8'h3C, 64'h0000777777770000);
        wr(6'd7, 64'h0000777777770000, 8'h3C);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("timeout_cs_idle%0d", i), 64'(sram_cs_o), (i == 4) ? 64'd1 : 64'd0);
            tick();
        end
        idle(1);

        // 6: flush with a valid entry
        push_wr(6'd1, 8'hFF, 64'h0101010101010101);
        wr(6'd1, 64'h0101010101010101, 8'hFF);
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_cyc_ready", 64'(req_ready_o), 64'd1);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(req_ready_o), 64'd0);
        chk("flush_cs", 64'(sram_cs_o), 64'd1);
        chk("flush_we", 64'(sram_we_o), 64'd1);
        chk("flush_done", 64'(flush_done_o), 64'd1);
        tick();
        @(negedge clk);
        chk("post_flush_done", 64'(flush_done_o), 64'd0);
        chk("post_flush_ready", 64'(req_ready_o), 64'd1);
        tick();

        // 6: flush on an empty buffer
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_empty_done", 64'(flush_done_o), 64'd1);
        chk("flush_empty_cs", 64'(sram_cs_o), 64'd0);
        tick();

        // Write accepted in the flush_i cycle is drained by that flush
        push_wr(6'd4, 8'h0F, 64'h0000000044444444);
        flush_i = 1'b1;
        wr(6'd4, 64'h0000000044444444, 8'h0F);
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_req_done", 64'(flush_done_o), 64'd1);
        chk("flush_req_cs", 64'(sram_cs_o), 64'd1);
        tick();
        // flush_i held through FLUSH is ignored there
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_held_done", 64'(flush_done_o), 64'd0);
        chk("flush_held_ready", 64'(req_ready_o), 64'd1);
        tick();
        rd(6'd4, 64'h14C0C1C244444444);
        idle(6);

        chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
        chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
